// File: rtl/axi_obi_responder.sv
// axi_obi_responder: AXI4 slave that terminates bursts and replays each beat as a single
// OBI master access. One AXI transaction at a time, at most one OBI access outstanding.
//
// Optional feature: define AXI_OBI_RESPONDER_WRAP_EN to support WRAP bursts with
// len in {1,3,7,15}. Without it, any WRAP burst is answered with SLVERR and no OBI traffic.
//
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   axi_req_i AXI slave request  (aw, w, ar channels, b_ready, r_ready)
//   axi_rsp_o AXI slave response (aw/ar/w ready, b and r channels)
//   obi_req_o OBI master request (req, addr, we, be, wdata)
//   obi_rsp_i OBI master response (gnt, rvalid, rdata, err)

package axi_obi_responder_pkg;
  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 32;

  typedef struct packed {
    logic [AxiIdWidth-1:0]     aw_id;
    logic [AxiAddrWidth-1:0]   aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_valid;
    logic [AxiDataWidth-1:0]   w_data;
    logic [AxiDataWidth/8-1:0] w_strb;
    logic                      w_last;
    logic                      w_valid;
    logic                      b_ready;
    logic [AxiIdWidth-1:0]     ar_id;
    logic [AxiAddrWidth-1:0]   ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_valid;
    logic                      r_ready;
  } axi_req_t;

  typedef struct packed {
    logic                    aw_ready;
    logic                    ar_ready;
    logic                    w_ready;
    logic                    b_valid;
    logic [AxiIdWidth-1:0]   b_id;
    logic [1:0]              b_resp;
    logic                    r_valid;
    logic [AxiIdWidth-1:0]   r_id;
    logic [AxiDataWidth-1:0] r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
  } axi_rsp_t;

  typedef struct packed {
    logic                      req;
    logic [AxiAddrWidth-1:0]   addr;
    logic                      we;
    logic [AxiDataWidth/8-1:0] be;
    logic [AxiDataWidth-1:0]   wdata;
  } obi_req_t;

  typedef struct packed {
    logic                    gnt;
    logic                    rvalid;
    logic [AxiDataWidth-1:0] rdata;
    logic                    err;
  } obi_resp_t;
endpackage

module axi_obi_responder
  import axi_obi_responder_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  axi_req_i,
  output axi_rsp_t  axi_rsp_o,
  output obi_req_t  obi_req_o,
  input  obi_resp_t obi_rsp_i
);

  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [1:0] BurstWrap = 2'b10;
  localparam logic [1:0] BurstRsvd = 2'b11;
  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [1:0] RespSlv   = 2'b10;

`ifdef AXI_OBI_RESPONDER_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle, StRdReq, StRdWait, StRdResp, StWrData, StWrReq, StWrWait, StWrResp
  } state_e;

  state_e                 state_q, state_d;
  logic                   prio_rd_q, prio_rd_d;
  logic [AxiIdWidth-1:0]  id_q, id_d;
  logic [AddrWidth-1:0]   addr_q, addr_d, addr_nxt;
  logic [1:0]             burst_q, burst_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   bad_q, bad_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   rerr_q, rerr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [DataWidth/8-1:0] strb_q, strb_d;
`ifdef AXI_OBI_RESPONDER_WRAP_EN
  logic [7:0]             len_q, len_d;
  logic [AddrWidth-1:0]   wrap_mask;
  // Window of (len+1)*4 bytes; for len in {1,3,7,15} the mask is simply {len, 2'b11}.
  assign wrap_mask = {{(AddrWidth-10){1'b0}}, len_q, 2'b11};
`endif

  logic ar_win, aw_win, idle;

  function automatic logic bad_cmd(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [7:0] len);
    logic wrap_ok;
    wrap_ok = WrapEn && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size != 3'd2) || (burst == BurstRsvd) || (burst == BurstWrap && !wrap_ok);
  endfunction

  assign idle   = (state_q == StIdle);
  assign ar_win = axi_req_i.ar_valid & (~axi_req_i.aw_valid | prio_rd_q);
  assign aw_win = axi_req_i.aw_valid & (~axi_req_i.ar_valid | ~prio_rd_q);

  always_comb begin
    addr_nxt = addr_q;
    case (burst_q)
      BurstIncr: addr_nxt = addr_q + AddrWidth'(4);
`ifdef AXI_OBI_RESPONDER_WRAP_EN
      BurstWrap: addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + AddrWidth'(4)) & wrap_mask);
`endif
      default:   addr_nxt = addr_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    prio_rd_d = prio_rd_q;
    id_d      = id_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    bad_d     = bad_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
`ifdef AXI_OBI_RESPONDER_WRAP_EN
    len_d     = len_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (ar_win) begin
          prio_rd_d = ~prio_rd_q;
          id_d      = axi_req_i.ar_id;
          addr_d    = axi_req_i.ar_addr;
          burst_d   = axi_req_i.ar_burst;
          cnt_d     = axi_req_i.ar_len;
          err_d     = 1'b0;
          bad_d     = bad_cmd(axi_req_i.ar_size, axi_req_i.ar_burst, axi_req_i.ar_len);
`ifdef AXI_OBI_RESPONDER_WRAP_EN
          len_d     = axi_req_i.ar_len;
`endif
          if (bad_d) begin
            // Bad bursts never touch OBI: the R buffer holds the canned error beat.
            rdata_d = '0;
            rerr_d  = 1'b1;
            state_d = StRdResp;
          end else begin
            state_d = StRdReq;
          end
        end else if (aw_win) begin
          prio_rd_d = ~prio_rd_q;
          id_d      = axi_req_i.aw_id;
          addr_d    = axi_req_i.aw_addr;
          burst_d   = axi_req_i.aw_burst;
          cnt_d     = axi_req_i.aw_len;
          err_d     = 1'b0;
          bad_d     = bad_cmd(axi_req_i.aw_size, axi_req_i.aw_burst, axi_req_i.aw_len);
`ifdef AXI_OBI_RESPONDER_WRAP_EN
          len_d     = axi_req_i.aw_len;
`endif
          state_d   = StWrData;
        end
      end
      StRdReq: if (obi_rsp_i.gnt) state_d = StRdWait;
      StRdWait: begin
        if (obi_rsp_i.rvalid) begin
          rdata_d = obi_rsp_i.rdata;
          rerr_d  = obi_rsp_i.err;
          state_d = StRdResp;
        end
      end
      StRdResp: begin
        if (axi_req_i.r_ready) begin
          if (cnt_q == 8'd0) begin
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = addr_nxt;
            state_d = bad_q ? StRdResp : StRdReq;
          end
        end
      end
      StWrData: begin
        if (axi_req_i.w_valid) begin
          wdata_d = axi_req_i.w_data;
          strb_d  = axi_req_i.w_strb;
          if (axi_req_i.w_last != (cnt_q == 8'd0)) err_d = 1'b1;
          if (!bad_q) begin
            state_d = StWrReq;
          end else if (cnt_q == 8'd0) begin
            state_d = StWrResp;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      StWrReq: if (obi_rsp_i.gnt) state_d = StWrWait;
      StWrWait: begin
        if (obi_rsp_i.rvalid) begin
          err_d = err_q | obi_rsp_i.err;
          if (cnt_q == 8'd0) begin
            state_d = StWrResp;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = addr_nxt;
            state_d = StWrData;
          end
        end
      end
      StWrResp: if (axi_req_i.b_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      prio_rd_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
`ifdef AXI_OBI_RESPONDER_WRAP_EN
      len_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      bad_q     <= bad_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
`ifdef AXI_OBI_RESPONDER_WRAP_EN
      len_q     <= len_d;
`endif
    end
  end

  // Outputs decode from registered state; payloads are zeroed while their valid is low.
  always_comb begin
    axi_rsp_o = '0;
    obi_req_o = '0;
    // Address readies are combinational; gating with rst_ni keeps them low during reset.
    axi_rsp_o.ar_ready = rst_ni & idle & ar_win;
    axi_rsp_o.aw_ready = rst_ni & idle & aw_win;
    axi_rsp_o.w_ready  = (state_q == StWrData);
    if (state_q == StRdResp) begin
      axi_rsp_o.r_valid = 1'b1;
      axi_rsp_o.r_id    = id_q;
      axi_rsp_o.r_data  = rdata_q;
      axi_rsp_o.r_resp  = rerr_q ? RespSlv : RespOkay;
      axi_rsp_o.r_last  = (cnt_q == 8'd0);
    end
    if (state_q == StWrResp) begin
      axi_rsp_o.b_valid = 1'b1;
      axi_rsp_o.b_id    = id_q;
      axi_rsp_o.b_resp  = (err_q | bad_q) ? RespSlv : RespOkay;
    end
    if (state_q == StRdReq) begin
      obi_req_o.req  = 1'b1;
      obi_req_o.addr = {addr_q[AddrWidth-1:2], 2'b00};
      obi_req_o.be   = '1;
    end
    if (state_q == StWrReq) begin
      obi_req_o.req   = 1'b1;
      obi_req_o.addr  = {addr_q[AddrWidth-1:2], 2'b00};
      obi_req_o.we    = 1'b1;
      obi_req_o.be    = strb_q;
      obi_req_o.wdata = wdata_q;
    end
  end

endmodule
